// File: rtl/ysyx_22050550_gpr_scoreboard_pkg.sv
// rtl/ysyx_22050550_gpr_scoreboard_pkg.sv - default sizes and counter type for the GPR scoreboard
// Package ysyx_22050550_rf_pkg: default XLEN/NREG/NRD/NWR/CNTW and the pending-counter type.
package ysyx_22050550_rf_pkg;

  localparam int DEF_XLEN = 64;
  localparam int DEF_NREG = 32;
  localparam int DEF_NRD  = 2;
  localparam int DEF_NWR  = 2;
  localparam int DEF_CNTW = 2;

  typedef logic [DEF_CNTW-1:0] cnt_t;

  // Largest value a pending counter of the given width can hold.
  function automatic int cnt_max(input int cntw);
    return (1 << cntw) - 1;
  endfunction

endpackage

// File: rtl/ysyx_22050550_gpr_scoreboard_if.sv
// rtl/ysyx_22050550_gpr_scoreboard_if.sv - issue, read and write-back bundle of the GPR scoreboard
// master: drives flush, issue_valid/issue_rd, rd_addr, wb_valid/wb_addr/wb_data;
//         sees issue_ready, rd_data, rd_busy, sb_err.
// slave : the scoreboard side (directions reversed).
interface ysyx_22050550_gpr_scoreboard_if
  import ysyx_22050550_rf_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter int NREG = DEF_NREG,
  parameter int NRD  = DEF_NRD,
  parameter int NWR  = DEF_NWR
) ();

  localparam int AW = $clog2(NREG);

  logic                flush;
  logic                issue_valid;
  logic [AW-1:0]       issue_rd;
  logic                issue_ready;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic [NWR-1:0]      wb_valid;
  logic [NWR*AW-1:0]   wb_addr;
  logic [NWR*XLEN-1:0] wb_data;
  logic                sb_err;

  modport master (
    output flush, issue_valid, issue_rd, rd_addr, wb_valid, wb_addr, wb_data,
    input  issue_ready, rd_data, rd_busy, sb_err
  );

  modport slave (
    input  flush, issue_valid, issue_rd, rd_addr, wb_valid, wb_addr, wb_data,
    output issue_ready, rd_data, rd_busy, sb_err
  );

endinterface

// File: rtl/ysyx_22050550_gpr_scoreboard_sb_cnt.sv
// rtl/ysyx_22050550_gpr_scoreboard_sb_cnt.sv - one saturating up/down pending counter
// Ports: clock, reset (sync, active-low), inc (+1), dec_n (-dec_n), clr (zero, wins over inc/dec),
//        cnt (current count), udf (this cycle's update would go below zero; counter clamps at 0).
module ysyx_22050550_sb_cnt
  import ysyx_22050550_rf_pkg::*;
#(
  parameter int CNTW = DEF_CNTW,
  parameter int DW   = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            inc,
  input  logic [DW-1:0]   dec_n,
  input  logic            clr,
  output logic [CNTW-1:0] cnt,
  output logic            udf
);

  localparam int PMAX = cnt_max(CNTW);

  logic [CNTW-1:0] cnt_q;
  logic [CNTW-1:0] cnt_d;
  int              nxt;

  always_comb begin
    cnt_d = cnt_q;
    udf   = 1'b0;
    nxt   = int'(cnt_q) + int'(inc) - int'(dec_n);
    if (clr) begin
      cnt_d = '0;
    end else if (nxt < 0) begin
      cnt_d = '0;
      udf   = 1'b1;
    end else if (nxt > PMAX) begin
      cnt_d = CNTW'(PMAX);
    end else begin
      cnt_d = CNTW'(nxt);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/ysyx_22050550_gpr_scoreboard.sv
// rtl/ysyx_22050550_gpr_scoreboard.sv - register file with per-register pending-write scoreboard
// Ports: clock, reset (sync, active-low), sb (slave modport of ysyx_22050550_gpr_scoreboard_if).
// Build option YSYX_22050550_WB_BYPASS_EN: reads see same-cycle write-back data and post-write busy.
module ysyx_22050550_gpr_scoreboard
  import ysyx_22050550_rf_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter int NREG = DEF_NREG,
  parameter int NRD  = DEF_NRD,
  parameter int NWR  = DEF_NWR,
  parameter int CNTW = DEF_CNTW
) (
  input logic                            clock,
  input logic                            reset,
  ysyx_22050550_gpr_scoreboard_if.slave  sb
);

  localparam int AW   = $clog2(NREG);
  localparam int DW   = $clog2(NWR + 1);
  localparam int PMAX = cnt_max(CNTW);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [CNTW-1:0] cnt_vec [NREG];
  logic [NREG-1:0] udf_vec;
  logic            sb_err_q;
  logic            sb_err_d;
  logic            issue_fire;

  // x0 is never allocatable, so it is always ready; otherwise a full counter,
  // a flush or reset blocks allocation.
  always_comb begin
    if (sb.issue_rd == '0) begin
      sb.issue_ready = 1'b1;
    end else begin
      sb.issue_ready = reset && !sb.flush && (cnt_vec[sb.issue_rd] != CNTW'(PMAX));
    end
  end

  assign issue_fire = sb.issue_valid && sb.issue_ready;

  // Ascending port order makes the highest-index write-back win.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      regs_d[i] = regs_q[i];
    end
    for (int j = 0; j < NWR; j++) begin
      if (sb.wb_valid[j] && (sb.wb_addr[j*AW +: AW] != '0)) begin
        regs_d[sb.wb_addr[j*AW +: AW]] = sb.wb_data[j*XLEN +: XLEN];
      end
    end
  end

  assign cnt_vec[0] = '0;
  assign udf_vec[0] = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_cnt
    logic          inc;
    logic [DW-1:0] dec_n;

    always_comb begin
      inc   = issue_fire && (sb.issue_rd == AW'(r));
      dec_n = '0;
      for (int j = 0; j < NWR; j++) begin
        if (sb.wb_valid[j] && (sb.wb_addr[j*AW +: AW] == AW'(r))) begin
          dec_n = dec_n + DW'(1);
        end
      end
    end

    ysyx_22050550_sb_cnt #(
      .CNTW (CNTW),
      .DW   (DW)
    ) u_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (inc),
      .dec_n (dec_n),
      .clr   (sb.flush),
      .cnt   (cnt_vec[r]),
      .udf   (udf_vec[r])
    );
  end

  assign sb_err_d = sb_err_q | (|udf_vec);

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      sb_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= regs_d[i];
      end
      sb_err_q <= sb_err_d;
    end
  end

  assign sb.sb_err = sb_err_q;

  always_comb begin : p_rd
    logic [AW-1:0] a;
    logic [XLEN-1:0] d;
    logic busy;
    int hits;
    sb.rd_data = '0;
    sb.rd_busy = '0;
    for (int k = 0; k < NRD; k++) begin
      a    = sb.rd_addr[k*AW +: AW];
      d    = regs_q[a];
      busy = (cnt_vec[a] != '0);
      hits = 0;
`ifdef YSYX_22050550_WB_BYPASS_EN
      for (int j = 0; j < NWR; j++) begin
        if (sb.wb_valid[j] && (sb.wb_addr[j*AW +: AW] == a)) begin
          d    = sb.wb_data[j*XLEN +: XLEN];
          hits = hits + 1;
        end
      end
      busy = (int'(cnt_vec[a]) > hits);
`endif
      if (a == '0) begin
        d    = '0;
        busy = 1'b0;
      end
      sb.rd_data[k*XLEN +: XLEN] = d;
      sb.rd_busy[k]              = busy;
    end
  end

endmodule
